i2c_target_unit: RTL

// I2C target (slave) byte engine: the responder end of the bus that i2cUnit drives as controller.

---
 rtl/i2c_target_unit_if.sv | 22 ++
 rtl/i2c_target_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_unit_if.sv
// Byte-level handshake between the I2C target engine and its register/FIFO front end.
// The target engine uses the slave modport; the front end uses master.
interface i2c_target_unit_if;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic       ackEnable;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       masterAck;

  modport slave (
    output rxData, rxValid, txReady, masterAck,
    input  rxReady, ackEnable, txData, txValid
  );

  modport master (
    input  rxData, rxValid, txReady, masterAck,
    output rxReady, ackEnable, txData, txValid
  );
endinterface

// File: rtl/i2c_target_unit.sv
// I2C target byte engine: START/STOP detection, 7-bit address match, write bytes to a
// valid/ready consumer, read bytes from a valid/ready producer, optional SCL stretching.
module i2c_target_unit #(
  parameter logic [6:0] ADDRESS    = 7'h50,
  parameter bit         STRETCH_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire              scl,
  inout  wire              sda,
  i2c_target_unit_if.slave host,
  output logic             startDet,
  output logic             stopDet,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_STALL, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, IGNORE
  } stateT;

  stateT       state;
  logic [1:0]  sclSync, sdaSync;
  logic        sclPrev, sdaPrev;
  logic        sclIn, sdaIn;
  logic        sclRise, sclFall, startCond, stopCond;
  logic [2:0]  bitCnt;
  logic [7:0]  shiftReg;
  logic [7:0]  nextByte;
  logic        phase;
  logic        rwBit;
  logic        ackLatch;
  logic        sclLow, sdaLow;

  assign scl = sclLow ? 1'b0 : 1'bz;
  assign sda = sdaLow ? 1'b0 : 1'bz;

  assign sclIn     = sclSync[1];
  assign sdaIn     = sdaSync[1];
  assign sclRise   = sclIn & ~sclPrev;
  assign sclFall   = ~sclIn & sclPrev;
  assign startCond = sclIn & sclPrev & sdaPrev & ~sdaIn;
  assign stopCond  = sclIn & sclPrev & ~sdaPrev & sdaIn;
  assign nextByte  = {shiftReg[6:0], sdaIn};

  always_ff @(posedge clk) begin
    if (reset) begin
      sclSync <= '1;
      sdaSync <= '1;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclSync <= {sclSync[0], scl};
      sdaSync <= {sdaSync[0], sda};
      sclPrev <= sclSync[1];
      sdaPrev <= sdaSync[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bitCnt         <= '0;
      shiftReg       <= '0;
      phase          <= 1'b0;
      rwBit          <= 1'b0;
      ackLatch       <= 1'b0;
      sclLow         <= 1'b0;
      sdaLow         <= 1'b0;
      host.rxData    <= '0;
      host.rxValid   <= 1'b0;
      host.txReady   <= 1'b0;
      host.masterAck <= 1'b1;
      startDet       <= 1'b0;
      stopDet        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      startDet     <= 1'b0;
      stopDet      <= 1'b0;
      host.txReady <= 1'b0;
      // A load later in this block overrides the clear, so accept+load keeps rxValid high.
      if (host.rxValid && host.rxReady) host.rxValid <= 1'b0;

      if (startCond) begin
        startDet <= 1'b1;
        state    <= ADDR;
        bitCnt   <= '0;
        phase    <= 1'b0;
        sclLow   <= 1'b0;
        sdaLow   <= 1'b0;
      end else if (stopCond) begin
        stopDet <= 1'b1;
        state   <= IDLE;
        busy    <= 1'b0;
        phase   <= 1'b0;
        sclLow  <= 1'b0;
        sdaLow  <= 1'b0;
      end else begin
        case (state)
          ADDR: if (sclRise) begin
            shiftReg <= nextByte;
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              if (nextByte[7:1] == ADDRESS) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
                rwBit <= nextByte[0];
                phase <= 1'b0;
              end else begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          ADDR_ACK: if (sclFall) begin
            if (!phase) begin
              sdaLow <= 1'b1;
              phase  <= 1'b1;
            end else begin
              sdaLow <= 1'b0;
              phase  <= 1'b0;
              bitCnt <= '0;
              state  <= rwBit ? TX_LOAD : RX_BYTE;
            end
          end
          RX_BYTE: if (sclRise) begin
            shiftReg <= nextByte;
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              if (!host.rxValid) begin
                host.rxData  <= nextByte;
                host.rxValid <= 1'b1;
                ackLatch     <= host.ackEnable;
                phase        <= 1'b0;
                state        <= RX_ACK;
              end else if (STRETCH_EN) begin
                phase <= 1'b0;
                state <= RX_STALL;
              end else begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          // phase 0: waiting for SCL low; phase 1: holding SCL until the consumer drains.
          RX_STALL: begin
            if (!phase) begin
              if (sclFall) begin
                sclLow <= 1'b1;
                phase  <= 1'b1;
              end
            end else if (!host.rxValid || host.rxReady) begin
              host.rxData  <= shiftReg;
              host.rxValid <= 1'b1;
              ackLatch     <= host.ackEnable;
              sdaLow       <= host.ackEnable;
              state        <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (sclLow) sclLow <= 1'b0;
            if (sclFall) begin
              if (!phase) begin
                sdaLow <= ackLatch;
                phase  <= 1'b1;
              end else begin
                sdaLow <= 1'b0;
                phase  <= 1'b0;
                bitCnt <= '0;
                if (ackLatch) state <= RX_BYTE;
                else begin
                  state <= IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          TX_LOAD: if (!sclIn) begin
            if (host.txValid) begin
              host.txReady <= 1'b1;
              shiftReg     <= host.txData;
              sdaLow       <= ~host.txData[7];
              bitCnt       <= '0;
              state        <= TX_BYTE;
            end else if (STRETCH_EN) begin
              sclLow <= 1'b1;
            end else begin
              shiftReg <= '1;
              sdaLow   <= 1'b0;
              bitCnt   <= '0;
              state    <= TX_BYTE;
            end
          end
          TX_BYTE: begin
            if (sclLow) sclLow <= 1'b0;
            if (sclFall) begin
              if (bitCnt == 3'd7) begin
                sdaLow <= 1'b0;
                state  <= TX_ACK;
              end else begin
                shiftReg <= {shiftReg[6:0], 1'b0};
                sdaLow   <= ~shiftReg[6];
                bitCnt   <= bitCnt + 3'd1;
              end
            end
          end
          TX_ACK: begin
            if (sclRise) begin
              host.masterAck <= sdaIn;
              if (sdaIn) begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end else if (sclFall) begin
              state <= TX_LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
